// File: rtl/mem_burst_pkg.sv
// Shared definitions for the memory burst initiator, its memory model and benches.
//   state_e            : initiator FSM states
//   SZ_*               : burst size codes (1/4/8/16 words)
//   num_beats()        : size code -> beat count
//   MEM_START_ADDRESS  : base byte address of main memory
package mem_burst_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StStream,
    StResp
  } state_e;

  localparam logic [1:0] SZ_1W  = 2'b00;
  localparam logic [1:0] SZ_4W  = 2'b01;
  localparam logic [1:0] SZ_8W  = 2'b10;
  localparam logic [1:0] SZ_16W = 2'b11;

  localparam logic [31:0] MEM_START_ADDRESS = 32'h8002_0000;

  function automatic logic [4:0] num_beats(input logic [1:0] size);
    logic [4:0] n;
    unique case (size)
      SZ_1W:   n = 5'd1;
      SZ_4W:   n = 5'd4;
      SZ_8W:   n = 5'd8;
      SZ_16W:  n = 5'd16;
      default: n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_burst_master.sv
// Initiator side of the main-memory access protocol.
// Accepts single-word read/write and burst-read requests from a CPU-side client, issues them
// to memory, and returns read words to the client one beat at a time.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        client request handshake
//   req_addr/req_wren/req_size/req_wdata   request fields (size forced to 1 word on writes)
//   rsp_valid/rsp_data/rsp_idx/rsp_last/rsp_err   one-cycle response beat, no backpressure
//   mem_addr/mem_acc_size/mem_wren/mem_enable/mem_d_in   memory command side
//   mem_d_out/mem_busy         memory read data and burst-in-progress flag
module mem_burst_master
  import mem_burst_pkg::*;
#(
  parameter int unsigned ADDRESS_SIZE = 32,
  parameter int unsigned DATA_SIZE    = 32,
  parameter int unsigned ACCESS_SIZE  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // client request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDRESS_SIZE-1:0] req_addr,
  input  logic                    req_wren,
  input  logic [ACCESS_SIZE-1:0]  req_size,
  input  logic [DATA_SIZE-1:0]    req_wdata,
  // client response
  output logic                    rsp_valid,
  output logic [DATA_SIZE-1:0]    rsp_data,
  output logic [3:0]              rsp_idx,
  output logic                    rsp_last,
  output logic                    rsp_err,
  // memory side
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [ACCESS_SIZE-1:0]  mem_acc_size,
  output logic                    mem_wren,
  output logic                    mem_enable,
  output logic [DATA_SIZE-1:0]    mem_d_in,
  input  logic [DATA_SIZE-1:0]    mem_d_out,
  input  logic                    mem_busy
);

  state_e                  state_q, state_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic                    wren_q, wren_d;
  logic [ACCESS_SIZE-1:0]  size_q, size_d;
  logic [DATA_SIZE-1:0]    wdata_q, wdata_d;
  logic [3:0]              k_q, k_d;

  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_SIZE-1:0]    rsp_data_q, rsp_data_d;
  logic [3:0]              rsp_idx_q, rsp_idx_d;
  logic                    rsp_last_q, rsp_last_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    accept;
  logic                    misaligned;
  logic [4:0]              beats;
  logic [3:0]              last_k;

  assign accept     = req_valid & req_ready;
  assign misaligned = |req_addr[1:0];
  assign beats      = num_beats(size_q[1:0]);
  assign last_k     = 4'(beats - 5'd1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latches, beat counter and registered response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      wren_q      <= 1'b0;
      size_q      <= '0;
      wdata_q     <= '0;
      k_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_idx_q   <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      wren_q      <= wren_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      k_q         <= k_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_idx_q   <= rsp_idx_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wren_d      = wren_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    k_d         = k_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = '0;
    rsp_idx_d   = '0;
    rsp_last_d  = 1'b0;
    rsp_err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = req_addr;
          wren_d  = req_wren;
          size_d  = req_wren ? ACCESS_SIZE'(SZ_1W) : req_size;
          wdata_d = req_wdata;
          k_d     = '0;
          if (misaligned) begin
            // Rejected without touching memory; error beat is visible while in StResp.
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_last_d  = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (wren_q) begin
          // Ack is registered on the write edge so it lands together with the return to
          // idle, like the last read beat; the client may issue again in the ack cycle.
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
        end else begin
          state_d = StStream;
          k_d     = '0;
        end
      end
      StStream: begin
        rsp_valid_d = 1'b1;
        rsp_data_d  = mem_d_out;
        rsp_idx_d   = k_q;
        rsp_last_d  = (k_q == last_k);
        if (k_q == last_k) begin
          state_d = StIdle;
        end else begin
          k_d = k_q + 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs
  always_comb begin
    req_ready    = (state_q == StIdle) && !mem_busy;
    mem_enable   = (state_q == StIssue);
    mem_wren     = (state_q == StIssue) && wren_q;
    mem_d_in     = (state_q == StIssue) ? wdata_q : '0;
    // Held for the whole burst: memory indexes words off the live address.
    mem_addr     = addr_q;
    mem_acc_size = size_q;
    rsp_valid    = rsp_valid_q;
    rsp_data     = rsp_data_q;
    rsp_idx      = rsp_idx_q;
    rsp_last     = rsp_last_q;
    rsp_err      = rsp_err_q;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
module tb_mem_burst_master;
  import mem_burst_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wren;
  logic [1:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_idx;
  logic        rsp_last;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [1:0]  mem_acc_size;
  logic        mem_wren;
  logic        mem_enable;
  logic [31:0] mem_d_in;
  logic [31:0] mem_d_out;
  logic        mem_busy;
  logic        force_busy;

  always #5 clk = ~clk;

  mem_burst_master #(
    .ADDRESS_SIZE(32),
    .DATA_SIZE   (32),
    .ACCESS_SIZE (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wren    (req_wren),
    .req_size    (req_size),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_idx     (rsp_idx),
    .rsp_last    (rsp_last),
    .rsp_err     (rsp_err),
    .mem_addr    (mem_addr),
    .mem_acc_size(mem_acc_size),
    .mem_wren    (mem_wren),
    .mem_enable  (mem_enable),
    .mem_d_in    (mem_d_in),
    .mem_d_out   (mem_d_out),
    .mem_busy    (mem_busy)
  );

  function automatic logic [7:0] widx(input logic [31:0] a);
    logic [31:0] t;
    t = (a - MEM_START_ADDRESS) >> 2;
    return t[7:0];
  endfunction

  function automatic int nb(input logic [1:0] s);
    case (s)
      2'd0:    return 1;
      2'd1:    return 4;
      2'd2:    return 8;
      default: return 16;
    endcase
  endfunction

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    if (i == 0) v = 32'hDEAD_BEEF;
    else if (i >= 4 && i <= 7) v = 32'h11 * (i - 3);
    else v = (i * 32'h0100_0193) ^ 32'h5A5A_0000;
    return v;
  endfunction

  // ---------------- memory model (environment) ----------------
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  logic        mstream = 1'b0;
  logic [3:0]  mk = 4'd0;
  int          mn = 1;

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] = init_word(i);
      mem_loaded <= 1'b1;
    end
    if (mem_enable && mem_wren) mem[widx(mem_addr)] = mem_d_in;
    if (mem_enable && !mem_wren) begin
      mstream <= 1'b1;
      mk      <= 4'd0;
      mn      <= nb(mem_acc_size);
    end else if (mstream) begin
      if (int'(mk) + 1 == mn) mstream <= 1'b0;
      else mk <= mk + 4'd1;
    end
  end

  assign mem_d_out = mstream ? mem[widx(mem_addr) + {4'd0, mk}] : 32'd0;
  assign mem_busy  = mstream | force_busy;

  // ---------------- reference model and checker ----------------
  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
    logic        err;
  } beat_t;

  beat_t       exp_q[$];
  beat_t       obs_q[$];
  logic [31:0] model_mem [256];
  logic        model_loaded = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          free_cyc = 0;
  int          issue_cyc = -1;
  int          win_end = -1;
  logic        issue_wr = 1'b0;
  logic [31:0] m_addr = '0;
  logic [1:0]  m_size = '0;
  logic [31:0] m_wdata = '0;
  int          n_acc = 0;
  int          last_acc_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic exp_valid;
    logic exp_ready;
    beat_t b;
    if (!model_loaded) begin
      for (int i = 0; i < 256; i++) model_mem[i] = init_word(i);
      model_loaded = 1'b1;
    end
    if (!rst_n) begin
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
      chk("rst_rsp_idx", {28'd0, rsp_idx}, 32'd0);
      chk("rst_rsp_last", {31'd0, rsp_last}, 32'd0);
      chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
      chk("rst_mem_enable", {31'd0, mem_enable}, 32'd0);
      chk("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_acc_size", {30'd0, mem_acc_size}, 32'd0);
      chk("rst_mem_d_in", mem_d_in, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, {31'd0, !mem_busy});
      exp_q.delete();
      free_cyc  = cyc;
      issue_cyc = -1;
      win_end   = -1;
    end else begin
      exp_valid = (exp_q.size() != 0) && (exp_q[0].cyc == cyc);
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, exp_valid});
      if (exp_valid) begin
        b = exp_q.pop_front();
        chk("rsp_data", rsp_data, b.data);
        chk("rsp_idx", {28'd0, rsp_idx}, {28'd0, b.idx});
        chk("rsp_last", {31'd0, rsp_last}, {31'd0, b.last});
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, b.err});
      end
      exp_ready = (cyc >= free_cyc) && !mem_busy;
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
      chk("mem_enable", {31'd0, mem_enable}, {31'd0, cyc == issue_cyc});
      chk("mem_wren", {31'd0, mem_wren}, {31'd0, (cyc == issue_cyc) && issue_wr});
      if (cyc == issue_cyc && issue_wr) chk("mem_d_in", mem_d_in, m_wdata);
      if (cyc >= issue_cyc && cyc <= win_end) begin
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_acc_size", {30'd0, mem_acc_size}, {30'd0, m_size});
      end
      if (rsp_valid) obs_q.push_back('{cyc, rsp_data, rsp_idx, rsp_last, rsp_err});
      // Acceptance decided from the model's own view of readiness.
      if (req_valid && exp_ready) begin
        n_acc++;
        last_acc_cyc = cyc;
        if (req_addr[1:0] != 2'd0) begin
          exp_q.push_back('{cyc + 1, 32'd0, 4'd0, 1'b1, 1'b1});
          free_cyc = cyc + 2;
        end else if (req_wren) begin
          issue_cyc = cyc + 1;
          win_end   = cyc + 1;
          issue_wr  = 1'b1;
          m_addr    = req_addr;
          m_size    = 2'd0;
          m_wdata   = req_wdata;
          model_mem[widx(req_addr)] = req_wdata;
          exp_q.push_back('{cyc + 2, 32'd0, 4'd0, 1'b1, 1'b0});
          free_cyc = cyc + 2;
        end else begin
          int n;
          n         = nb(req_size);
          issue_cyc = cyc + 1;
          win_end   = cyc + 1 + n;
          issue_wr  = 1'b0;
          m_addr    = req_addr;
          m_size    = req_size;
          for (int k = 0; k < n; k++) begin
            exp_q.push_back('{cyc + 3 + k, model_mem[widx(req_addr) + 8'(k)], 4'(k),
                              k == n - 1, 1'b0});
          end
          free_cyc = cyc + n + 2;
        end
      end
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] s,
                       input logic [31:0] d, output int acc);
    int n0;
    int g;
    n0 = n_acc;
    g  = 0;
    req_valid = 1'b1;
    req_addr  = a;
    req_wren  = w;
    req_size  = s;
    req_wdata = d;
    while (n_acc == n0 && g < 200) begin
      @(posedge clk);
      g++;
    end
    #1;
    req_valid = 1'b0;
    if (n_acc == n0) chk("accept_timeout", 32'd0, 32'd1);
    acc = last_acc_cyc;
  endtask

  task automatic wait_quiet();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || cyc < free_cyc || mem_busy) && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (g >= 100) chk("quiet_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_beat(input string name, input int i, input int ecyc,
                            input logic [31:0] data, input logic [3:0] idx,
                            input logic last, input logic err);
    if (obs_q.size() <= i) begin
      chk({name, "_missing"}, obs_q.size(), i + 1);
    end else begin
      chk({name, "_cyc"}, obs_q[i].cyc, ecyc);
      chk({name, "_data"}, obs_q[i].data, data);
      chk({name, "_idx"}, {28'd0, obs_q[i].idx}, {28'd0, idx});
      chk({name, "_last"}, {31'd0, obs_q[i].last}, {31'd0, last});
      chk({name, "_err"}, {31'd0, obs_q[i].err}, {31'd0, err});
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int a;
    int s;
    int n0;
    int g;
    logic [31:0] ra;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_wren   = 1'b0;
    req_size   = '0;
    req_wdata  = '0;
    force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single read
    obs_q.delete();
    issue(MEM_START_ADDRESS, 1'b0, SZ_1W, 32'd0, a);
    wait_quiet();
    chk("rd1_count", obs_q.size(), 32'd1);
    check_beat("rd1", 0, a + 3, 32'hDEAD_BEEF, 4'd0, 1'b1, 1'b0);

    // 4-word burst
    obs_q.delete();
    issue(MEM_START_ADDRESS + 32'h10, 1'b0, SZ_4W, 32'd0, a);
    wait_quiet();
    chk("b4_count", obs_q.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_beat("b4", i, a + 3 + i, 32'h11 * (i + 1), 4'(i), i == 3, 1'b0);
    end

    // Write (size code ignored) then read back
    obs_q.delete();
    issue(MEM_START_ADDRESS + 32'h20, 1'b1, SZ_4W, 32'hCAFE_F00D, a);
    wait_quiet();
    check_beat("wr_ack", 0, a + 2, 32'd0, 4'd0, 1'b1, 1'b0);
    obs_q.delete();
    issue(MEM_START_ADDRESS + 32'h20, 1'b0, SZ_1W, 32'd0, a);
    wait_quiet();
    check_beat("wr_rb", 0, a + 3, 32'hCAFE_F00D, 4'd0, 1'b1, 1'b0);

    // Misaligned request
    obs_q.delete();
    issue(MEM_START_ADDRESS + 32'h2, 1'b0, SZ_8W, 32'd0, a);
    wait_quiet();
    chk("mis_count", obs_q.size(), 32'd1);
    check_beat("mis", 0, a + 1, 32'd0, 4'd0, 1'b1, 1'b1);

    // mem_busy stall in idle
    obs_q.delete();
    s  = cyc;
    n0 = n_acc;
    force_busy = 1'b1;
    req_valid  = 1'b1;
    req_addr   = MEM_START_ADDRESS + 32'h10;
    req_wren   = 1'b0;
    req_size   = SZ_1W;
    repeat (3) @(posedge clk);
    #1 force_busy = 1'b0;
    g = 0;
    while (n_acc == n0 && g < 20) begin
      @(posedge clk);
      g++;
    end
    #1 req_valid = 1'b0;
    chk("stall_accepts", n_acc - n0, 32'd1);
    chk("stall_acc_cyc", last_acc_cyc, s + 3);
    wait_quiet();
    check_beat("stall_rd", 0, s + 6, 32'h11, 4'd0, 1'b1, 1'b0);

    // 16-word burst aborted by reset while beat 5 would be presented
    obs_q.delete();
    issue(MEM_START_ADDRESS + 32'h40, 1'b0, SZ_16W, 32'd0, a);
    g = 0;
    while (cyc < a + 8 && g < 50) begin
      @(posedge clk);
      #1;
      g++;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_quiet();
    chk("abort_count", obs_q.size(), 32'd5);
    check_beat("abort_b4", 4, a + 7, init_word(16 + 4), 4'd4, 1'b0, 1'b0);
    obs_q.delete();
    issue(MEM_START_ADDRESS, 1'b0, SZ_1W, 32'd0, a);
    wait_quiet();
    check_beat("post_rst", 0, a + 3, 32'hDEAD_BEEF, 4'd0, 1'b1, 1'b0);

    // Randomized traffic, including back-to-back requests and busy stalls
    for (int t = 0; t < 200; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        force_busy = ($urandom_range(0, 5) == 0);
        repeat (gap) @(posedge clk);
        #1 force_busy = 1'b0;
      end
      ra = MEM_START_ADDRESS + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 7) == 0) ra = ra + $urandom_range(1, 3);
      issue(ra, $urandom_range(0, 2) == 0, 2'($urandom_range(0, 3)), $urandom, a);
    end
    wait_quiet();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
